hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline stall logic for the MIPS core.
- Tracks, in an internal shift-register scoreboard, the destination register and remaining Tnew of every instruction downstream of Decode.
- Compares the Decode instruction's sources and Tuse against the scoreboard, then raises stall and per-source forward selects.
- Adds a multiply/divide busy counter so HI/LO consumers stall for a configurable latency.

Parameters:
- NSTAGE, 3, downstream stages tracked (E, M, W for 3); entry k = stage k+1.
- REGW, 5, register index width.
- TW, 2, Tuse/Tnew width.
- MUL_LAT, 5, cycles mult/multu keeps unit busy.
- DIV_LAT, 10, cycles div/divu keeps unit busy.
- SELW, clog2(NSTAGE+1), forward-select width (derived; not overridable).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- d_rs  in  REGW  Decode rs index.
- d_rt  in  REGW  Decode rt index.
- d_rs_use  in  TW  Tuse of rs.
- d_rt_use  in  TW  Tuse of rt.
- d_tar  in  REGW  Decode destination (0 = none).
- d_tnew  in  TW  Tnew the instruction will have on entering E.
- d_md_start  in  1  Decode instr is mult/multu/div/divu.
- d_md_div  in  1  1 = div type, 0 = mul type (valid with d_md_start).
- d_md_use  in  1  Decode instr touches HI/LO or the MD unit (mfhi/mflo/mthi/mtlo/mult/div).
- stall  out  1  freeze F/D, insert bubble into E.
- fwd_rs_sel  out  SELW  0 = register file; k = forward from stage k.
- fwd_rt_sel  out  SELW  as above for rt.
- md_busy  out  1  MD counter nonzero.

Behaviour:
- State: entry[0..NSTAGE-1] = {tar, tnew}; md_cnt (width holds max(MUL_LAT, DIV_LAT)).
- Reset (reset==0 at edge):
  - All entries {0,0}; md_cnt=0.
  - While reset low, stall=0, fwd_*_sel=0, md_busy=0.
  - Reset during MD operation aborts it; md_busy=0 on the next cycle.
- Shift each cycle:
  - entry[k] <= entry[k-1] with tnew_next = (tnew==0) ? 0 : tnew-1.
  - entry[0] <= stall ? {0,0} : {d_tar, d_tnew}.
  - Last entry is discarded.
- Register stall (combinational), per source s in {rs, rt}:
  - Any k with s!=0, entry[k].tar==s and s_use < entry[k].tnew asserts stall.
  - Register 0 never stalls and never forwards.
- MD stall: d_md_use && md_busy asserts stall.
- stall = OR of all stall terms; no latency.
- md_cnt:
  - If d_md_start && !stall: load DIV_LAT if d_md_div, else MUL_LAT (load wins over decrement).
  - Else if md_cnt!=0: decrement.
  - Saturates at 0.
  - md_busy = md_cnt!=0, registered state.
- Forward select, per source:
  - Find the youngest (lowest k) entry with matching nonzero tar.
  - Output k+1 if its tnew==0, else 0.
  - Older matches are shadowed by the youngest match even if they are ready.
  - When stall=1, selects are don't-care but still driven deterministically per the rule above.
- Simultaneous events:
  - Stall while MD instr is in Decode: no load; load occurs in the cycle it advances.
  - Back-to-back MD: the second sees md_busy and stalls until the first drains.
- Timing: no combinational path from d_* to state other than through stall into entry[0] and the md_cnt load.

Test Plan:
- Load-use, rs-read in E: lw (d_tar=1, d_tnew=2), then addu (d_rs=1, d_rs_use=1) held in D -> stall=1 for exactly 1 cycle; next cycle stall=0, entry M {1,1}, fwd_rs_sel=0.
- Branch after ALU: addu (d_tar=8, d_tnew=1), then beq (d_rs=8, d_rs_use=0) -> stall 1 cycle; then entry M tnew=0, fwd_rs_sel=2, stall=0.
- Register $0: lw with d_tar=0 followed by beq reading $0 -> stall=0 and fwd_rs_sel=0 throughout.
- Shadowing: addu writes $3 (tnew 1), then lw writes $3 (tnew 2), then addu reads rt=$3 with use 1 -> stall on the E match (1<2); the older M match must not select a forward.
- MD latency, default params: mult issues at cycle 0, mfhi in D at cycle 1 -> md_busy 1 for 5 cycles, stall=1 for cycles 1..5, stall=0 at cycle 6.
- MD latency with div: repeat the previous scenario with div -> stall for 10 cycles.
- Reset mid-operation: div issued, reset low for 1 cycle at count 4 -> next cycle md_busy=0, all entries zero, pending mfhi does not stall.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - pipeline hazard scoreboard with stall, forward select and MD busy tracking
module hazard_scoreboard #(
  parameter int NSTAGE  = 3,
  parameter int REGW    = 5,
  parameter int TW      = 2,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  localparam int SELW   = $clog2(NSTAGE + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [REGW-1:0] d_rs,
  input  logic [REGW-1:0] d_rt,
  input  logic [TW-1:0]   d_rs_use,
  input  logic [TW-1:0]   d_rt_use,
  input  logic [REGW-1:0] d_tar,
  input  logic [TW-1:0]   d_tnew,
  input  logic            d_md_start,
  input  logic            d_md_div,
  input  logic            d_md_use,
  output logic            stall,
  output logic [SELW-1:0] fwd_rs_sel,
  output logic [SELW-1:0] fwd_rt_sel,
  output logic            md_busy
);

  localparam int MD_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW     = $clog2(MD_MAX + 1);

  // Entry k describes the instruction currently in stage k+1 (E, M, W, ...)
  logic [REGW-1:0] tar_q  [NSTAGE];
  logic [TW-1:0]   tnew_q [NSTAGE];
  logic [CW-1:0]   md_cnt_q;

  logic            stall_raw;
  logic [SELW-1:0] rs_sel_raw;
  logic [SELW-1:0] rt_sel_raw;
  logic            rs_found;
  logic            rt_found;

  // Hazard detection and youngest-match forward selection against the scoreboard
  always_comb begin
    stall_raw  = 1'b0;
    rs_sel_raw = '0;
    rt_sel_raw = '0;
    rs_found   = 1'b0;
    rt_found   = 1'b0;
    for (int k = 0; k < NSTAGE; k++) begin
      if (d_rs != '0 && tar_q[k] == d_rs) begin
        if (d_rs_use < tnew_q[k]) stall_raw = 1'b1;
        if (!rs_found) begin
          rs_found   = 1'b1;
          rs_sel_raw = (tnew_q[k] == '0) ? SELW'(k + 1) : '0;
        end
      end
      if (d_rt != '0 && tar_q[k] == d_rt) begin
        if (d_rt_use < tnew_q[k]) stall_raw = 1'b1;
        if (!rt_found) begin
          rt_found   = 1'b1;
          rt_sel_raw = (tnew_q[k] == '0) ? SELW'(k + 1) : '0;
        end
      end
    end
    if (d_md_use && md_cnt_q != '0) stall_raw = 1'b1;
  end

  assign stall      = reset & stall_raw;
  assign fwd_rs_sel = reset ? rs_sel_raw : '0;
  assign fwd_rt_sel = reset ? rt_sel_raw : '0;
  assign md_busy    = reset & (md_cnt_q != '0);

  // Scoreboard shift: a stalled Decode inserts a bubble, older entries age by one cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NSTAGE; k++) begin
        tar_q[k]  <= '0;
        tnew_q[k] <= '0;
      end
    end else begin
      for (int k = 1; k < NSTAGE; k++) begin
        tar_q[k]  <= tar_q[k-1];
        tnew_q[k] <= (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - TW'(1);
      end
      tar_q[0]  <= stall ? '0 : d_tar;
      tnew_q[0] <= stall ? '0 : d_tnew;
    end
  end

  // MD busy counter: load on an issuing mult/div, otherwise count down to zero
  always_ff @(posedge clk) begin
    if (!reset) begin
      md_cnt_q <= '0;
    end else if (d_md_start && !stall) begin
      md_cnt_q <= d_md_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_q <= md_cnt_q - CW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_tar;
  logic [1:0] d_rs_use, d_rt_use, d_tnew;
  logic       d_md_start, d_md_div, d_md_use;
  logic       stall, md_busy;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;

  int total = 0;
  int bad   = 0;

  hazard_scoreboard dut (
    .clk        (clk),
    .reset      (reset),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_rs_use   (d_rs_use),
    .d_rt_use   (d_rt_use),
    .d_tar      (d_tar),
    .d_tnew     (d_tnew),
    .d_md_start (d_md_start),
    .d_md_div   (d_md_div),
    .d_md_use   (d_md_use),
    .stall      (stall),
    .fwd_rs_sel (fwd_rs_sel),
    .fwd_rt_sel (fwd_rt_sel),
    .md_busy    (md_busy)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] rsu, input logic [1:0] rtu,
                       input logic [4:0] tar, input logic [1:0] tnew,
                       input logic mds, input logic mdd, input logic mdu);
    d_rs = rs; d_rt = rt; d_rs_use = rsu; d_rt_use = rtu;
    d_tar = tar; d_tnew = tnew;
    d_md_start = mds; d_md_div = mdd; d_md_use = mdu;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // reset with hazard-provoking inputs: outputs must stay quiet
    reset = 1'b0;
    drive(1, 1, 0, 0, 1, 2, 1, 1, 1);
    cyc();
    settle();
    chk("rst_stall", stall, 0);
    chk("rst_rs_sel", fwd_rs_sel, 0);
    chk("rst_md_busy", md_busy, 0);
    cyc();
    idle();
    reset = 1'b1;
    cyc();
    cyc();

    // load-use: lw $1 (tnew 2) then addu reading $1 with use 1
    drive(0, 0, 0, 0, 1, 2, 0, 0, 0);
    settle();
    chk("lu_lw_nostall", stall, 0);
    cyc();
    drive(1, 0, 1, 0, 2, 1, 0, 0, 0);
    settle();
    chk("lu_stall", stall, 1);
    chk("lu_sel_e", fwd_rs_sel, 0);
    cyc();
    settle();
    chk("lu_release", stall, 0);
    chk("lu_sel_m", fwd_rs_sel, 0);
    cyc();
    idle();
    cyc(); cyc(); cyc();

    // branch after ALU: addu $8 (tnew 1) then beq reading $8 with use 0
    drive(0, 0, 0, 0, 8, 1, 0, 0, 0);
    settle();
    chk("br_alu_nostall", stall, 0);
    cyc();
    drive(8, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("br_stall", stall, 1);
    chk("br_sel_stalled", fwd_rs_sel, 0);
    cyc();
    settle();
    chk("br_release", stall, 0);
    chk("br_sel_m", fwd_rs_sel, 2);
    cyc();
    settle();
    chk("br_sel_w", fwd_rs_sel, 3);
    cyc();
    settle();
    chk("br_sel_gone", fwd_rs_sel, 0);
    idle();
    cyc(); cyc(); cyc();

    // register $0: lw $0 then beq reading $0 on both sources
    drive(0, 0, 0, 0, 0, 2, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("r0_stall", stall, 0);
    chk("r0_rs_sel", fwd_rs_sel, 0);
    cyc();
    settle();
    chk("r0_rt_sel", fwd_rt_sel, 0);
    chk("r0_stall2", stall, 0);
    cyc(); cyc();

    // shadowing: addu $3 (tnew 1), lw $3 (tnew 2), addu reading rt=$3 use 1
    drive(0, 0, 0, 0, 3, 1, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 3, 2, 0, 0, 0);
    cyc();
    drive(0, 3, 0, 1, 4, 1, 0, 0, 0);
    settle();
    chk("sh_stall", stall, 1);
    chk("sh_rt_sel", fwd_rt_sel, 0);
    chk("sh_rs_sel", fwd_rs_sel, 0);
    cyc();
    settle();
    chk("sh_release", stall, 0);
    chk("sh_rt_sel_m", fwd_rt_sel, 0);
    cyc();
    settle();
    chk("sh_rt_sel_w", fwd_rt_sel, 3);
    idle();
    cyc(); cyc(); cyc();

    // mult then mfhi: busy 5 cycles
    drive(0, 0, 0, 0, 0, 0, 1, 0, 1);
    settle();
    chk("mul_issue_stall", stall, 0);
    chk("mul_issue_busy", md_busy, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 5; i++) begin
      settle();
      chk($sformatf("mul_stall_c%0d", i), stall, 1);
      chk($sformatf("mul_busy_c%0d", i), md_busy, 1);
      cyc();
    end
    settle();
    chk("mul_done_stall", stall, 0);
    chk("mul_done_busy", md_busy, 0);
    idle();
    cyc(); cyc();

    // div then mfhi: busy 10 cycles
    drive(0, 0, 0, 0, 0, 0, 1, 1, 1);
    settle();
    chk("div_issue_stall", stall, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 10; i++) begin
      settle();
      chk($sformatf("div_stall_c%0d", i), stall, 1);
      cyc();
    end
    settle();
    chk("div_done_stall", stall, 0);
    chk("div_done_busy", md_busy, 0);
    idle();
    cyc(); cyc();

    // reset mid-operation at count 4, with a pending lw $5 in the scoreboard
    drive(0, 0, 0, 0, 0, 0, 1, 1, 1);
    cyc();
    idle();
    for (int i = 0; i < 5; i++) cyc();
    drive(0, 0, 0, 0, 5, 2, 0, 0, 0);
    settle();
    chk("rm_busy_before", md_busy, 1);
    cyc();
    drive(5, 0, 0, 0, 0, 0, 0, 0, 1);
    settle();
    chk("rm_hazard_live", stall, 1);
    reset = 1'b0;
    #1;
    chk("rm_rstlow_stall", stall, 0);
    chk("rm_rstlow_busy", md_busy, 0);
    cyc();
    reset = 1'b1;
    settle();
    chk("rm_after_busy", md_busy, 0);
    chk("rm_after_stall", stall, 0);
    chk("rm_after_sel", fwd_rs_sel, 0);
    cyc();
    settle();
    chk("rm_after_stall2", stall, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
